// File: rtl/probe_req_dispatcher.sv
// probe_req_dispatcher: routes a single stream of probe requests to per-slice
// FIFOs selected by address bank bits, and drives each slice's enqueue
// valid/ready handshake straight from FIFO storage so valid stays stable.
// Also keeps per-slice stall statistics and a sticky stall alarm.
module probe_req_dispatcher #(
  parameter int ADDR_W      = 36,
  parameter int NUM_SLICES  = 4,
  parameter int SLICE_LSB   = 6,
  parameter int DEPTH       = 2,
  parameter int STALL_LIMIT = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [1:0]                 in_param,
  output logic [NUM_SLICES-1:0]      out_valid,
  input  logic [NUM_SLICES-1:0]      out_ready,
  output logic [NUM_SLICES*ADDR_W-1:0] out_addr,
  output logic [NUM_SLICES*2-1:0]    out_param,
  output logic [NUM_SLICES*16-1:0]   stall_cnt,
  output logic [NUM_SLICES-1:0]      stall_alarm
);

  localparam int SEL_W = $clog2(NUM_SLICES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int ENT_W = ADDR_W + 2;

  // Entry storage carries no reset: it is only observed while out_valid is high.
  logic [ENT_W-1:0]      r_mem   [NUM_SLICES][DEPTH];
  logic [PTR_W-1:0]      r_wptr  [NUM_SLICES];
  logic [PTR_W-1:0]      r_rptr  [NUM_SLICES];
  logic [15:0]           r_run   [NUM_SLICES];
  logic [15:0]           r_stall [NUM_SLICES];
  logic [NUM_SLICES-1:0] r_alarm;

  logic [SEL_W-1:0]      w_sel;
  logic [NUM_SLICES-1:0] w_empty;
  logic [NUM_SLICES-1:0] w_full;
  logic [NUM_SLICES-1:0] w_enq;
  logic [NUM_SLICES-1:0] w_deq;
  logic [NUM_SLICES-1:0] w_stall;
  logic [15:0]           w_run_nxt [NUM_SLICES];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // FIFO status from pointers; the top pointer bit is the wrap bit.
  always_comb begin
    w_empty = '0;
    w_full  = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      w_empty[i] = (r_wptr[i] == r_rptr[i]);
      w_full[i]  = (r_wptr[i][IDX_W-1:0] == r_rptr[i][IDX_W-1:0]) &&
                   (r_wptr[i][IDX_W] != r_rptr[i][IDX_W]);
    end
  end

  // Slice select and upstream ready; a full FIFO blocks even if it drains this cycle.
  always_comb begin
    w_sel    = in_addr[SLICE_LSB +: SEL_W];
    in_ready = reset & ~w_full[w_sel];
  end

  // Per-slice handshake decode and next run-length value.
  always_comb begin
    w_enq   = '0;
    w_deq   = '0;
    w_stall = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      w_enq[i]     = in_valid & in_ready & (w_sel == SEL_W'(i));
      w_deq[i]     = ~w_empty[i] & out_ready[i];
      w_stall[i]   = ~w_empty[i] & ~out_ready[i];
      w_run_nxt[i] = w_deq[i] ? 16'd0 : (w_stall[i] ? sat_inc(r_run[i]) : r_run[i]);
    end
  end

  // Head-of-queue outputs come only from storage, never from the in_* path.
  always_comb begin
    out_valid   = '0;
    out_addr    = '0;
    out_param   = '0;
    stall_cnt   = '0;
    stall_alarm = r_alarm;
    for (int i = 0; i < NUM_SLICES; i++) begin
      out_valid[i]               = ~w_empty[i];
      out_addr[i*ADDR_W +: ADDR_W] = r_mem[i][r_rptr[i][IDX_W-1:0]][ENT_W-1:2];
      out_param[i*2 +: 2]        = r_mem[i][r_rptr[i][IDX_W-1:0]][1:0];
      stall_cnt[i*16 +: 16]      = r_stall[i];
    end
  end

  // Write accepted requests into the selected slice's storage.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (w_enq[i]) begin
        r_mem[i][r_wptr[i][IDX_W-1:0]] <= {in_addr, in_param};
      end
    end
  end

  // Pointer advance; reset empties every FIFO and drops buffered entries.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SLICES; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLICES; i++) begin
        if (w_enq[i]) r_wptr[i] <= r_wptr[i] + PTR_W'(1);
        if (w_deq[i]) r_rptr[i] <= r_rptr[i] + PTR_W'(1);
      end
    end
  end

  // Stall run-length, total stall count and sticky alarm per slice.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_alarm <= '0;
      for (int i = 0; i < NUM_SLICES; i++) begin
        r_run[i]   <= '0;
        r_stall[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLICES; i++) begin
        r_run[i] <= w_run_nxt[i];
        if (w_stall[i]) r_stall[i] <= sat_inc(r_stall[i]);
        if (w_run_nxt[i] >= 16'(STALL_LIMIT)) r_alarm[i] <= 1'b1;
      end
    end
  end

endmodule
